sb_config_loader: RTL
=====================

Name: sb_config_loader

Overview:
- Initiator side of the switch-box configuration interface.
- Consumes a 32-bit configuration bitstream over a valid/ready word stream.
- Decodes (tile address, data) records and drives the shared config_data bus plus a one-hot per-tile config_en strobe, which each tile's sb_config register captures.
- Sits at the array edge, between the bitstream source (SPI/host FIFO) and all tiles.

Parameters:
- width, 32, configuration word width; matches sb_config width.
- num_tiles, 16, number of tiles addressed; legal range 1..65536.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load from IDLE or DONE.
- bs_data  input  width  bitstream word.
- bs_valid  input  1  bs_data valid.
- bs_ready  output  1  loader accepts a word this cycle.
- config_data  output  width  shared config word to all tiles.
- config_en  output  num_tiles  one-hot write strobe; bit i loads tile i.
- busy  output  1  load in progress.
- done  output  1  load completed without error; sticky.
- err  output  1  protocol error; sticky.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; bs_ready, config_en, config_data, busy, done, err all 0; record counter 0. Reset mid-load aborts immediately. No partial strobe after reset deasserts.
- Stream format:
  - Word 0: record count N (full width, unsigned).
  - Then N records of two words each: address word (bits [15:0] = tile index, upper bits ignored), then data word.
- Transfer: a word is accepted on a cycle with bs_valid && bs_ready. bs_ready is a registered state decode, high only in CNT, ADDR, DATA (and CHK with the option). It does not depend on bs_valid combinationally.
- FSM states: IDLE, CNT, ADDR, DATA, WR, DONE, ERR (CHK with the option).
  - IDLE: start -> CNT, busy=1.
  - DONE: start -> clear done, go to CNT, busy=1.
  - start is ignored in every other state.
  - CNT: on accept, latch N. If N==0 -> DONE (or CHK). Otherwise -> ADDR.
  - ADDR: on accept, if tile index >= num_tiles -> ERR with no write. Otherwise latch the index and go to DATA.
  - DATA: on accept, register the word into config_data -> WR.
  - WR: one cycle with config_en[addr]=1, all other bits 0, bs_ready=0. Decrement the counter. If it reaches 0 -> DONE (or CHK); otherwise -> ADDR.
  - DONE: done=1, busy=0.
  - ERR: err=1, busy=0, bs_ready=0. Leaves only via reset.
- Write latency: config_data and config_en update on the edge after the data word is accepted. config_en lasts exactly one cycle, with config_data stable during it.
- config_data holds its last value between writes.
- Minimum record spacing is 3 cycles (ADDR, DATA, WR). Sustained back-to-back bs_valid never produces overlapping strobes.
- bs_valid may drop at any time. The FSM waits in its current state, with no timeout.
- Counter width is width bits, decremented only in WR, so no wrap is possible.
- Repeated writes to the same tile are legal; the last write wins.

Optional Feature:
- Macro: SB_CONFIG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last record (or after N==0), enter CHK.
  - CHK accepts one word and compares it to the running XOR of the count word and every address and data word accepted.
  - Match -> DONE; mismatch -> ERR.
  - The running XOR clears on reset and on start.
- Undefined: no CHK state and no XOR register. The FSM goes straight to DONE. Any trailing word is not consumed (bs_ready=0).

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with bs_valid=1 -> bs_ready=0, config_en=0, config_data=0, done=err=busy=0.
- Single record: start, then stream 1, 0x3, 0xDEADBEEF -> exactly one cycle with config_en=0x0008 and config_data=0xDEADBEEF; then done=1, busy=0.
- Multi-record with stalls: N=3 writing tiles 0, 15, 0 with data 0x1, 0x2, 0x3, and bs_valid toggled randomly -> three strobes in order 0x0001, 0x8000, 0x0001 with matching data, at least 2 cycles apart.
- Bad address: N=2, first record tile 16 (num_tiles=16) -> err=1, config_en never asserted, bs_ready=0 thereafter, start ignored until reset.
- Zero count and restart: stream N=0 -> done=1 with no strobes; a second start with N=1, tile 5, data 0xA5 -> done clears, strobe 0x0020, done=1.
- Checksum (macro defined): stream 1, 0x2, 0x10 then 0x13 -> done=1. Same stream with a final word of 0x12 -> err=1, with the tile-2 strobe having already occurred.

Source files
------------

// File: rtl/sb_config_loader.sv
// Switch-box configuration initiator: decodes (tile, data) records from a word stream
// and drives the shared config_data bus with a one-hot config_en strobe.
// Optional trailing XOR checksum word: define SB_CONFIG_LOADER_CHECKSUM_EN.
module sb_config_loader #(
    parameter int width     = 32,
    parameter int num_tiles = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [width-1:0]     bs_data,
    input  logic                 bs_valid,
    output logic                 bs_ready,
    output logic [width-1:0]     config_data,
    output logic [num_tiles-1:0] config_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_CNT = 3'd1, ST_ADDR = 3'd2, ST_DATA = 3'd3,
        ST_WR   = 3'd4, ST_DONE = 3'd5, ST_ERR = 3'd6, ST_CHK = 3'd7
    } state_t;
    localparam state_t ST_FINAL = ST_CHK;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_CNT = 3'd1, ST_ADDR = 3'd2, ST_DATA = 3'd3,
        ST_WR   = 3'd4, ST_DONE = 3'd5, ST_ERR = 3'd6
    } state_t;
    localparam state_t ST_FINAL = ST_DONE;
`endif

    localparam logic [16:0]      TILE_LIMIT = 17'(num_tiles);
    localparam logic [width-1:0] CNT_ONE    = {{(width-1){1'b0}}, 1'b1};

    state_t                 state_r;
    state_t                 next_s;
    logic                   accept_s;
    logic                   addr_ok_s;
    logic                   ready_next_s;
    logic                   busy_next_s;
    logic [width-1:0]       cnt_r;
    logic [15:0]            addr_r;
    logic                   bs_ready_r;
    logic [width-1:0]       config_data_r;
    logic [num_tiles-1:0]   config_en_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
    logic [width-1:0]       xor_r;
`endif

    function automatic logic [num_tiles-1:0] tile_strobe(input logic [15:0] idx);
        logic [num_tiles-1:0] v;
        v = '0;
        for (int i = 0; i < num_tiles; i++) begin
            v[i] = (idx == 16'(i));
        end
        return v;
    endfunction

    // Next-state decode plus the state classes that drive the registered outputs.
    always_comb begin
        next_s    = state_r;
        accept_s  = bs_valid && bs_ready_r;
        addr_ok_s = ({1'b0, bs_data[15:0]} < TILE_LIMIT);
        case (state_r)
            ST_IDLE: if (start) next_s = ST_CNT; else next_s = state_r;
            ST_CNT: begin
                if (accept_s) begin
                    if (bs_data == '0) next_s = ST_FINAL; else next_s = ST_ADDR;
                end else begin
                    next_s = state_r;
                end
            end
            ST_ADDR: begin
                if (accept_s) begin
                    if (addr_ok_s) next_s = ST_DATA; else next_s = ST_ERR;
                end else begin
                    next_s = state_r;
                end
            end
            ST_DATA: if (accept_s) next_s = ST_WR; else next_s = state_r;
            ST_WR:   if (cnt_r == CNT_ONE) next_s = ST_FINAL; else next_s = ST_ADDR;
            ST_DONE: if (start) next_s = ST_CNT; else next_s = state_r;
            ST_ERR:  next_s = ST_ERR;
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    if (bs_data == xor_r) next_s = ST_DONE; else next_s = ST_ERR;
                end else begin
                    next_s = state_r;
                end
            end
`endif
            default: next_s = ST_IDLE;
        endcase
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
        ready_next_s = (next_s == ST_CNT) || (next_s == ST_ADDR) ||
                       (next_s == ST_DATA) || (next_s == ST_CHK);
`else
        ready_next_s = (next_s == ST_CNT) || (next_s == ST_ADDR) || (next_s == ST_DATA);
`endif
        busy_next_s = ready_next_s || (next_s == ST_WR);
    end

    // State, datapath and registered outputs; outputs are decoded from next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            addr_r        <= 16'h0000;
            bs_ready_r    <= 1'b0;
            config_data_r <= '0;
            config_en_r   <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
            xor_r         <= '0;
`endif
        end else begin
            state_r    <= next_s;
            bs_ready_r <= ready_next_s;
            busy_r     <= busy_next_s;
            done_r     <= (next_s == ST_DONE);
            err_r      <= (next_s == ST_ERR);
            // The strobe fires in WR only, so it lands one edge after the data word.
            if (state_r == ST_DATA && accept_s) begin
                config_en_r   <= tile_strobe(addr_r);
                config_data_r <= bs_data;
            end else begin
                config_en_r   <= '0;
            end
            if (state_r == ST_CNT && accept_s) begin
                cnt_r <= bs_data;
            end else if (state_r == ST_WR) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            if (state_r == ST_ADDR && accept_s) begin
                addr_r <= bs_data[15:0];
            end
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
            if ((state_r == ST_IDLE || state_r == ST_DONE) && start) begin
                xor_r <= '0;
            end else if (accept_s && state_r != ST_CHK) begin
                xor_r <= xor_r ^ bs_data;
            end
`endif
        end
    end

    assign bs_ready    = bs_ready_r;
    assign config_data = config_data_r;
    assign config_en   = config_en_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule
